// File: rtl/game_pkg.sv
// Shared game definitions: lifecycle state encoding and pipe geometry
// used by both the pipe generator and the bird controller.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPlaying = 2'd1,
    StDead    = 2'd2
  } game_state_e;

  localparam int INVALID         = -1;
  localparam int SCREEN_WIDTH    = 640;
  localparam int PIPE_WIDTH      = 52;
  localparam int PIPE_GAP_HEIGHT = 100;
  localparam int PIPE_DISTANCE   = 240;
  localparam int PIPE_Y_MIN      = 40;

  // Score add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, n};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/pipe_hit_checker.sv
// Per-pipe collision and pass detection against the fixed-X bird box.
module pipe_hit_checker
  import game_pkg::*;
#(
  parameter int BIRD_X = 100,
  parameter int BIRD_W = 34,
  parameter int BIRD_H = 24
) (
  input  logic signed [31:0] pipe_x,
  input  logic signed [31:0] pipe_y,
  input  logic signed [31:0] bird_y,
  input  logic signed [31:0] prev_edge,
  output logic               hit,
  output logic               pass
);

  logic signed [31:0] right_edge;
  logic               valid;
  logic               overlap;
  logic               in_gap;

  always_comb begin
    right_edge = pipe_x + PIPE_WIDTH;
    valid      = (pipe_y != INVALID);
    overlap    = (BIRD_X + BIRD_W > pipe_x) && (BIRD_X < right_edge);
    in_gap     = (bird_y >= pipe_y) && (bird_y + BIRD_H <= pipe_y + PIPE_GAP_HEIGHT);
    hit        = valid && overlap && !in_gap;
    // A recycle jump moves the edge from negative to large, so it never satisfies this.
    pass       = valid && (prev_edge >= BIRD_X) && (right_edge < BIRD_X);
  end

endmodule

// File: rtl/bird_state_controller.sv
// Bird physics, collision/pass scoring and the IDLE/PLAYING/DEAD lifecycle
// that feeds the pipe generator and renderer.
module bird_state_controller
  import game_pkg::*;
#(
  parameter int          BIRD_X        = 100,
  parameter int          BIRD_W        = 34,
  parameter int          BIRD_H        = 24,
  parameter int          BIRD_Y_START  = 228,
  parameter int          GROUND_Y      = 480,
  parameter int          GRAVITY       = 1,
  parameter int          FLAP_VELOCITY = -8,
  parameter int          MAX_FALL      = 8,
  parameter int unsigned PHYS_DIVIDER  = 200000,
  parameter int unsigned DEAD_HOLDOFF  = 100
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iFlap,
  input  logic signed [31:0] iPipe1X,
  input  logic signed [31:0] iPipe1Y,
  input  logic signed [31:0] iPipe2X,
  input  logic signed [31:0] iPipe2Y,
  input  logic signed [31:0] iPipe3X,
  input  logic signed [31:0] iPipe3Y,
  output logic [1:0]         oState,
  output logic signed [31:0] oBirdY,
  output logic [15:0]        oScore,
  output logic [15:0]        oHighScore,
  output logic               oCollision,
  output logic               oScorePulse
);

  localparam int unsigned HOLD_LIMIT = DEAD_HOLDOFF * PHYS_DIVIDER;

  game_state_e        state_q, state_d;
  logic signed [31:0] bird_y_q, bird_y_d;
  logic signed [31:0] vel_q, vel_d;
  logic [31:0]        tick_q, tick_d;
  logic [31:0]        hold_q, hold_d;
  logic [15:0]        score_q, score_d;
  logic [15:0]        high_q, high_d;
  logic               collision_q, collision_d;
  logic               pulse_q, pulse_d;
  logic               flap_prev_q;
  logic signed [31:0] prev_edge_q [3];

  logic signed [31:0] pipe_x [3];
  logic signed [31:0] pipe_y [3];
  logic [2:0]         hit;
  logic [2:0]         pass;
  logic [1:0]         pass_cnt;
  logic               flap_edge;
  logic               collide;
  logic signed [31:0] vel_grav;

  always_comb begin
    pipe_x[0] = iPipe1X;
    pipe_x[1] = iPipe2X;
    pipe_x[2] = iPipe3X;
    pipe_y[0] = iPipe1Y;
    pipe_y[1] = iPipe2Y;
    pipe_y[2] = iPipe3Y;
  end

  for (genvar i = 0; i < 3; i++) begin : g_pipe
    pipe_hit_checker #(
      .BIRD_X (BIRD_X),
      .BIRD_W (BIRD_W),
      .BIRD_H (BIRD_H)
    ) u_hit_checker (
      .pipe_x    (pipe_x[i]),
      .pipe_y    (pipe_y[i]),
      .bird_y    (bird_y_q),
      .prev_edge (prev_edge_q[i]),
      .hit       (hit[i]),
      .pass      (pass[i])
    );
  end

  always_comb begin
    flap_edge = iFlap & ~flap_prev_q;
    collide   = (bird_y_q < 0) || (bird_y_q + BIRD_H > GROUND_Y) || (|hit);
    pass_cnt  = {1'b0, pass[0]} + {1'b0, pass[1]} + {1'b0, pass[2]};
    vel_grav  = vel_q + GRAVITY;
    if (vel_grav > MAX_FALL) vel_grav = MAX_FALL;
  end

  always_comb begin
    state_d     = state_q;
    bird_y_d    = bird_y_q;
    vel_d       = vel_q;
    tick_d      = tick_q;
    hold_d      = hold_q;
    score_d     = score_q;
    high_d      = high_q;
    collision_d = 1'b0;
    pulse_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        bird_y_d = BIRD_Y_START;
        vel_d    = '0;
        tick_d   = '0;
        hold_d   = '0;
        if (flap_edge) begin
          state_d = StPlaying;
          vel_d   = FLAP_VELOCITY;
          score_d = '0;
        end
      end
      StPlaying: begin
        if (collide) begin
          // Collision beats a same-cycle flap or pass.
          state_d     = StDead;
          collision_d = 1'b1;
          tick_d      = '0;
          hold_d      = '0;
          if (score_q > high_q) high_d = score_q;
        end else begin
          if (tick_q == PHYS_DIVIDER - 1) begin
            tick_d   = '0;
            bird_y_d = bird_y_q + vel_q;
            vel_d    = vel_grav;
          end else begin
            tick_d = tick_q + 1;
          end
          if (flap_edge) vel_d = FLAP_VELOCITY;
          if (pass_cnt != 2'd0) begin
            score_d = sat_add16(score_q, pass_cnt);
            pulse_d = 1'b1;
          end
        end
      end
      StDead: begin
        if (hold_q < HOLD_LIMIT) begin
          hold_d = hold_q + 1;
        end else if (flap_edge) begin
          state_d  = StIdle;
          bird_y_d = BIRD_Y_START;
          vel_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= StIdle;
      bird_y_q    <= BIRD_Y_START;
      vel_q       <= '0;
      tick_q      <= '0;
      hold_q      <= '0;
      score_q     <= '0;
      high_q      <= '0;
      collision_q <= 1'b0;
      pulse_q     <= 1'b0;
      flap_prev_q <= 1'b0;
      for (int i = 0; i < 3; i++) prev_edge_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bird_y_q    <= bird_y_d;
      vel_q       <= vel_d;
      tick_q      <= tick_d;
      hold_q      <= hold_d;
      score_q     <= score_d;
      high_q      <= high_d;
      collision_q <= collision_d;
      pulse_q     <= pulse_d;
      flap_prev_q <= iFlap;
      for (int i = 0; i < 3; i++) prev_edge_q[i] <= pipe_x[i] + PIPE_WIDTH;
    end
  end

  assign oState      = state_q;
  assign oBirdY      = bird_y_q;
  assign oScore      = score_q;
  assign oHighScore  = high_q;
  assign oCollision  = collision_q;
  assign oScorePulse = pulse_q;

endmodule

// File: tb/tb_bird_state_controller.sv
// Directed bench for bird_state_controller with a short physics tick and holdoff.
`timescale 1ns/1ps
module tb_bird_state_controller;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iFlap;
  logic signed [31:0] iPipe1X, iPipe1Y, iPipe2X, iPipe2Y, iPipe3X, iPipe3Y;
  logic [1:0]         oState;
  logic signed [31:0] oBirdY;
  logic [15:0]        oScore;
  logic [15:0]        oHighScore;
  logic               oCollision;
  logic               oScorePulse;

  int n_cmp = 0;
  int n_err = 0;

  bird_state_controller #(
    .PHYS_DIVIDER (4),
    .DEAD_HOLDOFF (2)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iFlap       (iFlap),
    .iPipe1X     (iPipe1X),
    .iPipe1Y     (iPipe1Y),
    .iPipe2X     (iPipe2X),
    .iPipe2Y     (iPipe2Y),
    .iPipe3X     (iPipe3X),
    .iPipe3Y     (iPipe3Y),
    .oState      (oState),
    .oBirdY      (oBirdY),
    .oScore      (oScore),
    .oHighScore  (oHighScore),
    .oCollision  (oCollision),
    .oScorePulse (oScorePulse)
  );

  always #5 iClock = ~iClock;

  task automatic cyc(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    iReset  = 1'b1;
    iFlap   = 1'b0;
    iPipe1X = 600; iPipe1Y = -1;
    iPipe2X = 600; iPipe2Y = -1;
    iPipe3X = 600; iPipe3Y = -1;
    cyc(2);
    chk("rst_state", oState, 0);
    chk("rst_y", oBirdY, 228);
    chk("rst_score", oScore, 0);
    chk("rst_high", oHighScore, 0);
    chk("rst_col", oCollision, 0);
    chk("rst_pulse", oScorePulse, 0);

    iReset = 1'b0;
    cyc(1);
    chk("idle_state", oState, 0);
    iFlap = 1'b1;
    cyc(1);
    chk("start_state", oState, 1);
    chk("start_y", oBirdY, 228);
    chk("start_score", oScore, 0);
    iFlap = 1'b0;

    // Ticks every 4 clocks; velocity climbs from -8 and clamps at 8.
    cyc(3);  chk("pre_tick_y", oBirdY, 228);
    cyc(1);  chk("tick1_y", oBirdY, 220);
    cyc(4);  chk("tick2_y", oBirdY, 213);
    cyc(4);  chk("tick3_y", oBirdY, 207);
    cyc(60); chk("tick18_y", oBirdY, 236);
    cyc(4);  chk("tick19_y", oBirdY, 244);

    // Pass through a gap: the edge crosses BIRD_X on the 48 -> 47 step.
    iPipe1Y = 210; iPipe1X = 49; cyc(1);
    iPipe1X = 48; cyc(1);
    chk("pass_pre_score", oScore, 0);
    chk("pass_pre_pulse", oScorePulse, 0);
    iPipe1X = 47; cyc(1);
    chk("pass_score", oScore, 1);
    chk("pass_pulse", oScorePulse, 1);
    cyc(1);
    chk("pass_pulse_off", oScorePulse, 0);
    chk("tick20_y", oBirdY, 252);
    iPipe1X = -53; cyc(1);
    iPipe1X = 772; cyc(1);
    chk("recycle_score", oScore, 1);
    chk("recycle_pulse", oScorePulse, 0);

    // Overlapping pipe: harmless when invalid, fatal when valid.
    iPipe1X = 90; iPipe1Y = -1; cyc(2);
    chk("invalid_state", oState, 1);
    chk("invalid_col", oCollision, 0);
    iPipe1Y = 300; cyc(1);
    chk("hit_state", oState, 2);
    chk("hit_col", oCollision, 1);
    chk("hit_high", oHighScore, 1);
    chk("hit_y", oBirdY, 260);
    cyc(1);
    chk("dead_col_off", oCollision, 0);
    chk("dead_state", oState, 2);
    chk("dead_score", oScore, 1);

    // Holdoff of 8 clocks in DEAD.
    cyc(3);
    iFlap = 1'b1; cyc(1);
    chk("holdoff_ignore", oState, 2);
    iFlap = 1'b0; cyc(4);
    iFlap = 1'b1; cyc(1);
    chk("revive_state", oState, 0);
    chk("revive_y", oBirdY, 228);
    chk("revive_score", oScore, 1);
    iFlap = 1'b0; iPipe1Y = -1; cyc(1);
    iFlap = 1'b1; cyc(1);
    chk("restart_state", oState, 1);
    chk("restart_score", oScore, 0);
    chk("restart_high", oHighScore, 1);

    // Three pipes pass together every 2 clocks; flap every 68 clocks keeps the bird aloft.
    iPipe1Y = 210; iPipe2Y = 210; iPipe3Y = 210;
    for (int k = 0; k < 43692; k++) begin
      iFlap   = ((k + 1) % 68 == 0);
      iPipe1X = (k % 2 == 0) ? 48 : 47;
      iPipe2X = (k % 2 == 0) ? 48 : 47;
      iPipe3X = (k % 2 == 0) ? 48 : 47;
      cyc(1);
      if (k == 1) begin
        chk("multi_pass_score", oScore, 3);
        chk("multi_pass_pulse", oScorePulse, 1);
      end
      if (k == 2) chk("multi_pass_pulse_off", oScorePulse, 0);
      if (k == 43689) chk("score_full", oScore, 16'hFFFF);
    end
    chk("sat_score", oScore, 16'hFFFF);
    chk("sat_pulse", oScorePulse, 1);
    chk("sat_state", oState, 1);
    chk("sat_y", oBirdY, 192);

    // Reset in the middle of a game.
    iFlap  = 1'b0;
    iReset = 1'b1; cyc(1);
    chk("mid_rst_state", oState, 0);
    chk("mid_rst_y", oBirdY, 228);
    chk("mid_rst_score", oScore, 0);
    chk("mid_rst_high", oHighScore, 0);
    chk("mid_rst_col", oCollision, 0);
    chk("mid_rst_pulse", oScorePulse, 0);
    iReset = 1'b0; cyc(1);
    iFlap = 1'b1; cyc(1);
    chk("post_rst_state", oState, 1);
    iFlap = 1'b0; cyc(4);
    chk("post_rst_tick_y", oBirdY, 220);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
